// File: rtl/gat_bram_loader.sv
`default_nettype none
// ============================================================================
// Module      : gat_bram_loader
// Description : Unpacks one 32-bit host stream into write transactions for
//               the GAT core's H data, H node-info and weight BRAMs (in that
//               order) and raises a sticky per-region load-done flag.
// Revision    : 1.0 - initial release
// ============================================================================
module gat_bram_loader #(
    parameter int DATA_WIDTH       = 8,
    parameter int H_DATA_WIDTH     = 19,
    parameter int NODE_INFO_WIDTH  = 20,
    parameter int H_DATA_DEPTH     = 242101,
    parameter int NODE_INFO_DEPTH  = 13264,
    parameter int WEIGHT_DEPTH     = 22928,
    parameter int H_DATA_ADDR_W    = $clog2(H_DATA_DEPTH),
    parameter int NODE_INFO_ADDR_W = $clog2(NODE_INFO_DEPTH),
    parameter int WEIGHT_ADDR_W    = $clog2(WEIGHT_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [31:0]                   s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic                          s_tlast,
    output logic [H_DATA_WIDTH-1:0]       h_data_bram_din,
    output logic                          h_data_bram_ena,
    output logic                          h_data_bram_wea,
    output logic [H_DATA_ADDR_W+1:0]      h_data_bram_addra,
    output logic [NODE_INFO_WIDTH-1:0]    h_node_info_bram_din,
    output logic                          h_node_info_bram_ena,
    output logic                          h_node_info_bram_wea,
    output logic [NODE_INFO_ADDR_W+1:0]   h_node_info_bram_addra,
    output logic [DATA_WIDTH-1:0]         wgt_bram_din,
    output logic                          wgt_bram_ena,
    output logic                          wgt_bram_wea,
    output logic [WEIGHT_ADDR_W+1:0]      wgt_bram_addra,
    output logic                          h_data_bram_load_done,
    output logic                          h_node_info_bram_load_done,
    output logic                          wgt_bram_load_done,
    output logic                          busy,
    output logic                          tlast_err
);

    // One shared entry counter, wide enough for the deepest region
    localparam int c_IDX_W_HI = (H_DATA_ADDR_W > NODE_INFO_ADDR_W) ? H_DATA_ADDR_W : NODE_INFO_ADDR_W;
    localparam int c_IDX_W    = (c_IDX_W_HI > WEIGHT_ADDR_W) ? c_IDX_W_HI : WEIGHT_ADDR_W;

    localparam logic [c_IDX_W-1:0] c_H_LAST    = c_IDX_W'(H_DATA_DEPTH - 1);
    localparam logic [c_IDX_W-1:0] c_INFO_LAST = c_IDX_W'(NODE_INFO_DEPTH - 1);
    localparam logic [c_IDX_W-1:0] c_WGT_LAST  = c_IDX_W'(WEIGHT_DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LD_H    = 3'd1,
        ST_LD_INFO = 3'd2,
        ST_LD_WGT  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                         r_state;
    logic [c_IDX_W-1:0]             r_idx;

    logic [H_DATA_WIDTH-1:0]        r_h_din;
    logic                           r_h_we;
    logic [H_DATA_ADDR_W+1:0]       r_h_addr;
    logic [NODE_INFO_WIDTH-1:0]     r_info_din;
    logic                           r_info_we;
    logic [NODE_INFO_ADDR_W+1:0]    r_info_addr;
    logic [DATA_WIDTH-1:0]          r_wgt_din;
    logic                           r_wgt_we;
    logic [WEIGHT_ADDR_W+1:0]       r_wgt_addr;

    // Done/error events are staged one cycle so flags trail the write strobe
    logic [2:0]                     r_done_pend;
    logic [2:0]                     r_done;
    logic                           r_err_pend;
    logic                           r_err;

    logic                           w_in_load;
    logic                           w_beat;
    logic                           w_last;
    logic                           w_final;
    logic                           w_unused_tdata;

    // Ready/busy are a decode of the registered state
    assign w_in_load = (r_state == ST_LD_H) || (r_state == ST_LD_INFO) || (r_state == ST_LD_WGT);
    assign w_beat    = s_tvalid & w_in_load;
    assign w_final   = (r_state == ST_LD_WGT) && w_last;

    // Upper stream bits are don't-care for every region
    assign w_unused_tdata = ^s_tdata;

    // Region-end detect against the active region's own depth
    always_comb begin
        w_last = 1'b0;
        case (r_state)
            ST_LD_H:    w_last = (r_idx == c_H_LAST);
            ST_LD_INFO: w_last = (r_idx == c_INFO_LAST);
            ST_LD_WGT:  w_last = (r_idx == c_WGT_LAST);
            default:    w_last = 1'b0;
        endcase
    end

    // Sequencer: state, entry counter, write ports and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_h_din     <= '0;
            r_h_we      <= 1'b0;
            r_h_addr    <= '0;
            r_info_din  <= '0;
            r_info_we   <= 1'b0;
            r_info_addr <= '0;
            r_wgt_din   <= '0;
            r_wgt_we    <= 1'b0;
            r_wgt_addr  <= '0;
            r_done_pend <= '0;
            r_done      <= '0;
            r_err_pend  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_h_we      <= 1'b0;
            r_info_we   <= 1'b0;
            r_wgt_we    <= 1'b0;
            r_done      <= r_done | r_done_pend;
            r_err       <= r_err | r_err_pend;
            r_done_pend <= '0;
            r_err_pend  <= 1'b0;

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_LD_H;
                        r_idx      <= '0;
                        r_done     <= '0;
                        r_err      <= 1'b0;
                    end
                end
                ST_LD_H, ST_LD_INFO, ST_LD_WGT: begin
                    if (w_beat) begin
                        // tlast must mark exactly the final weight beat
                        r_err_pend <= s_tlast ^ w_final;
                        r_idx      <= w_last ? '0 : r_idx + 1'b1;
                        if (r_state == ST_LD_H) begin
                            r_h_din  <= s_tdata[H_DATA_WIDTH-1:0];
                            r_h_addr <= {r_idx[H_DATA_ADDR_W-1:0], 2'b00};
                            r_h_we   <= 1'b1;
                            if (w_last) begin
                                r_state        <= ST_LD_INFO;
                                r_done_pend[2] <= 1'b1;
                            end
                        end else if (r_state == ST_LD_INFO) begin
                            r_info_din  <= s_tdata[NODE_INFO_WIDTH-1:0];
                            r_info_addr <= {r_idx[NODE_INFO_ADDR_W-1:0], 2'b00};
                            r_info_we   <= 1'b1;
                            if (w_last) begin
                                r_state        <= ST_LD_WGT;
                                r_done_pend[1] <= 1'b1;
                            end
                        end else begin
                            r_wgt_din  <= s_tdata[DATA_WIDTH-1:0];
                            r_wgt_addr <= {r_idx[WEIGHT_ADDR_W-1:0], 2'b00};
                            r_wgt_we   <= 1'b1;
                            if (w_last) begin
                                r_state        <= ST_DONE;
                                r_done_pend[0] <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_tready                   = w_in_load;
    assign busy                       = w_in_load;
    assign tlast_err                  = r_err;
    assign h_data_bram_din            = r_h_din;
    assign h_data_bram_ena            = r_h_we;
    assign h_data_bram_wea            = r_h_we;
    assign h_data_bram_addra          = r_h_addr;
    assign h_node_info_bram_din       = r_info_din;
    assign h_node_info_bram_ena       = r_info_we;
    assign h_node_info_bram_wea       = r_info_we;
    assign h_node_info_bram_addra     = r_info_addr;
    assign wgt_bram_din               = r_wgt_din;
    assign wgt_bram_ena               = r_wgt_we;
    assign wgt_bram_wea               = r_wgt_we;
    assign wgt_bram_addra             = r_wgt_addr;
    assign h_data_bram_load_done      = r_done[2];
    assign h_node_info_bram_load_done = r_done[1];
    assign wgt_bram_load_done         = r_done[0];

endmodule
`default_nettype wire
